// File: rtl/dummy_imem_resp.sv
// Instruction-memory responder: one request at a time, fixed-latency single-cycle data pulse.
// Optional macro IMEM_JITTER_EN adds 0..3 cycles of LFSR-driven latency jitter per request.
//
// Ports:
//   i_clk, i_rst           clock; asynchronous active-high reset
//   i_req_ready/i_req_addr request strobe and word address from the cache
//   o_data_valid/o_bus     one-cycle response pulse and registered returned word
//   o_err_oob              pulses with o_data_valid for an out-of-range address
//   o_addr_valid           unsolicited-refill indication, tied low
//   i_load_en/addr/data    preload write port, usable in any cycle
module dummy_imem_resp #(
    parameter int          ADDRESS_LENGTH = 30,
    parameter int          WRITE_LANE     = 32,
    parameter int          DEPTH_LOG2     = 10,
    parameter int          LATENCY        = 3,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_ready,
    input  logic [ADDRESS_LENGTH-1:0] i_req_addr,
    output logic                      o_data_valid,
    output logic                      o_addr_valid,
    output logic [WRITE_LANE-1:0]     o_bus,
    output logic                      o_err_oob,
    input  logic                      i_load_en,
    input  logic [DEPTH_LOG2-1:0]     i_load_addr,
    input  logic [WRITE_LANE-1:0]     i_load_data
);

    localparam int CW = $clog2(LATENCY + 4) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                    state, state_n;
    logic [CW-1:0]             cnt, cnt_n, load_val;
    logic [ADDRESS_LENGTH-1:0] addr_q, addr_n;
    logic                      accept, enter_resp;
    logic [WRITE_LANE-1:0]     mem [0:(2**DEPTH_LOG2)-1];
    logic [WRITE_LANE-1:0]     bus_q, rd_data;
    logic                      oob_q, rd_oob;
    logic [DEPTH_LOG2-1:0]     rd_idx;

`ifdef IMEM_JITTER_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; steps once per accepted request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign load_val = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
`else
    assign load_val = CW'(LATENCY - 1);
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        addr_n     = addr_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_req_ready) begin
                    accept = 1'b1;
                    addr_n = i_req_addr;
                    cnt_n  = load_val;
                    if (load_val == '0) begin
                        state_n    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // addr_n is the incoming address when entering RESP straight from IDLE
    assign rd_idx = addr_n[DEPTH_LOG2-1:0];
    assign rd_oob = |addr_n[ADDRESS_LENGTH-1:DEPTH_LOG2];

    always_comb begin
        rd_data = mem[rd_idx];
        if (i_load_en && (i_load_addr == rd_idx)) begin
            rd_data = i_load_data;
        end
        if (rd_oob) begin
            rd_data = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            bus_q  <= '0;
            oob_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            if (enter_resp) begin
                bus_q <= rd_data;
                oob_q <= rd_oob;
            end
        end
    end

    // Array is deliberately outside reset so preloads survive i_rst
    always_ff @(posedge i_clk) begin
        if (i_load_en) begin
            mem[i_load_addr] <= i_load_data;
        end
    end

    assign o_data_valid = (state == ST_RESP);
    assign o_err_oob    = o_data_valid & oob_q;
    assign o_bus        = bus_q;
    assign o_addr_valid = 1'b0;

endmodule

// File: tb/tb_dummy_imem_resp.sv
// Scoreboard bench for dummy_imem_resp: driver queues expected pulses,
// a negedge monitor pops and checks data, error flag and arrival cycle.
module tb_dummy_imem_resp;

    localparam int AL  = 30;
    localparam int WL  = 32;
    localparam int DL  = 10;
    localparam int LAT = 3;
`ifdef IMEM_JITTER_EN
    localparam int JIT = 3;
`else
    localparam int JIT = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_req_ready = 1'b0;
    logic [AL-1:0] i_req_addr = '0;
    logic          o_data_valid;
    logic          o_addr_valid;
    logic [WL-1:0] o_bus;
    logic          o_err_oob;
    logic          i_load_en = 1'b0;
    logic [DL-1:0] i_load_addr = '0;
    logic [WL-1:0] i_load_data = '0;

    dummy_imem_resp #(
        .ADDRESS_LENGTH(AL),
        .WRITE_LANE(WL),
        .DEPTH_LOG2(DL),
        .LATENCY(LAT),
        .LFSR_SEED(8'hA5)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_req_ready(i_req_ready),
        .i_req_addr(i_req_addr),
        .o_data_valid(o_data_valid),
        .o_addr_valid(o_addr_valid),
        .o_bus(o_bus),
        .o_err_oob(o_err_oob),
        .i_load_en(i_load_en),
        .i_load_addr(i_load_addr),
        .i_load_data(i_load_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [WL-1:0] data;
        logic          oob;
        int            cyc;
        bit            rel;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_pulse = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WL-1:0] act,
                       input logic [WL-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic chk_win(input string name, input int act,
                           input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_miss++;
            $display("FAIL %s: got cycle %0d expected %0d..%0d",
                     name, act, lo, hi);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation
    always @(negedge i_clk) begin
        if (o_data_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pulse: got bus %h expected no pulse",
                         o_bus);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bus", o_bus, e.data);
                chk("oob", {31'b0, o_err_oob}, {31'b0, e.oob});
                chk("addr_valid", {31'b0, o_addr_valid}, 32'd0);
                if (e.rel)
                    chk_win("gap", cyc, last_pulse + LAT + 1,
                            last_pulse + LAT + 1 + JIT);
                else
                    chk_win("latency", cyc, e.cyc, e.cyc + JIT);
            end
            last_pulse = cyc;
        end
    end

    task automatic load(input int a, input logic [WL-1:0] d);
        @(negedge i_clk);
        i_load_en   = 1'b1;
        i_load_addr = DL'(a);
        i_load_data = d;
        @(negedge i_clk);
        i_load_en = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge i_clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge i_clk);
    endtask

    // Single request; address changed to addr2 right after acceptance
    task automatic req(input logic [AL-1:0] addr, input logic [AL-1:0] addr2,
                       input logic [WL-1:0] d, input logic oob);
        @(negedge i_clk);
        i_req_ready = 1'b1;
        i_req_addr  = addr;
        @(posedge i_clk);
        #1;
        sb.push_back('{data: d, oob: oob, cyc: cyc + LAT - 1, rel: 1'b0});
        @(negedge i_clk);
        i_req_ready = 1'b0;
        i_req_addr  = addr2;
        wait_done();
    endtask

    // Cache-like stream: ready held, address stepped by incr on each pulse
    task automatic stream(input logic [AL-1:0] base, input int n,
                          input int incr, input logic [WL-1:0] d0,
                          input int dstep);
        int k;
        int t;
        @(negedge i_clk);
        i_req_ready = 1'b1;
        i_req_addr  = base;
        @(posedge i_clk);
        #1;
        for (int i = 0; i < n; i++)
            sb.push_back('{data: d0 + WL'(i * dstep), oob: 1'b0,
                           cyc: cyc + LAT - 1, rel: (i != 0)});
        k = 0;
        t = 0;
        while (k < n && t < 80) begin
            @(negedge i_clk);
            t++;
            if (o_data_valid) begin
                k++;
                if (k == n) i_req_ready = 1'b0;
                else i_req_addr = i_req_addr + AL'(incr);
            end
        end
        i_req_ready = 1'b0;
        wait_done();
    endtask

    initial begin
        @(negedge i_clk);
        chk("rst_valid", {31'b0, o_data_valid}, 32'd0);
        chk("rst_oob", {31'b0, o_err_oob}, 32'd0);
        chk("rst_bus", o_bus, 32'd0);
        chk("rst_addr_valid", {31'b0, o_addr_valid}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        load(5, 32'h0000_0013);
        load(0, 32'h0000_00A0);
        load(2, 32'h0000_0222);
        load(9, 32'h0000_0999);
        load(4, 32'h0000_0044);

        // Held ready on one address: responses spaced LATENCY+1 apart
        stream(AL'(5), 2, 0, 32'h0000_0013, 0);

        load(5, 32'd1);
        load(6, 32'd2);
        load(7, 32'd3);
        stream(AL'(5), 3, 1, 32'd1, 1);

        req(AL'('h400), AL'('h400), 32'd0, 1'b1);
        req(AL'(0), AL'(0), 32'h0000_00A0, 1'b0);

        req(AL'(2), AL'(9), 32'h0000_0222, 1'b0);

        // Write-first bypass on the response-entry edge
        @(negedge i_clk);
        i_req_ready = 1'b1;
        i_req_addr  = AL'(4);
        @(posedge i_clk);
        #1;
        sb.push_back('{data: 32'hDEAD_BEEF, oob: 1'b0,
                       cyc: cyc + LAT - 1, rel: 1'b0});
        @(negedge i_clk);
        i_req_ready = 1'b0;
        i_load_addr = DL'(4);
        i_load_data = 32'hDEAD_BEEF;
`ifdef IMEM_JITTER_EN
        i_load_en = 1'b1;
        wait_done();
        i_load_en = 1'b0;
`else
        repeat (LAT - 2) @(negedge i_clk);
        i_load_en = 1'b1;
        @(negedge i_clk);
        i_load_en = 1'b0;
        wait_done();
`endif
        req(AL'(4), AL'(4), 32'hDEAD_BEEF, 1'b0);

        load(5, 32'h0000_0013);

        // Reset in the wait state abandons the request
        @(negedge i_clk);
        i_req_ready = 1'b1;
        i_req_addr  = AL'(2);
        @(negedge i_clk);
        i_req_ready = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (8) @(negedge i_clk);
        chk("post_rst_valid", {31'b0, o_data_valid}, 32'd0);
        chk("post_rst_bus", o_bus, 32'd0);

        req(AL'(5), AL'(5), 32'h0000_0013, 1'b0);

        repeat (4) @(negedge i_clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
